// File: rtl/dpd_mag_cordic.sv
// CORDIC vectoring magnitude front-end for the DPD actuator, with a bit-exact aligned sample delay line.
// Optional build macro DPD_MAG_SAT_CNT_EN adds sat_clr / sat_cnt (count of clipped magnitudes).
module dpd_mag_cordic #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int ITER       = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tu_enable,
  input  logic [DATA_WIDTH-1:0] tu,
`ifdef DPD_MAG_SAT_CNT_EN
  input  logic                  sat_clr,
  output logic [15:0]           sat_cnt,
`endif
  output logic [DATA_WIDTH-1:0] tu_out,
  output logic                  tu_out_enable,
  output logic [ADDR_WIDTH-1:0] mag
);
  localparam int HW  = DATA_WIDTH / 2;
  localparam int H   = HW + 2;
  localparam int S   = HW - 1 - ADDR_WIDTH;
  localparam int LAT = ITER + 3;
  localparam logic [14:0] GAIN_K  = 15'd19898;
  localparam logic [H:0]  RND     = {{H{1'b0}}, 1'b1} << (S - 1);
  localparam logic [H:0]  MAG_MAX = {{(H + 1 - ADDR_WIDTH){1'b0}}, {ADDR_WIDTH{1'b1}}};

  logic [DATA_WIDTH-1:0] gated_s;
  logic signed [H:0]     abs_i_s;
  logic signed [H:0]     abs_q_s;
  logic signed [H:0]     x_r [0:ITER];
  logic signed [H:0]     y_r [0:ITER];
  logic [DATA_WIDTH-1:0] data_r [0:LAT-1];
  logic [LAT-1:0]        vld_r;
  logic [H+14:0]         prod_s;
  logic [H-1:0]          xg_r;
  logic [H:0]            round_s;
  logic [H:0]            r_s;
  logic                  sat_s;
  logic [ADDR_WIDTH-1:0] mag_r;
  logic                  unused_s;

  // Sign-extend one half to H+1 bits and take its magnitude; -2^(HW-1) stays positive.
  function automatic logic signed [H:0] abs_ext(input logic [HW-1:0] v);
    logic signed [H:0] e;
    e = {{(H + 1 - HW){v[HW-1]}}, v};
    if (v[HW-1]) begin
      abs_ext = -e;
    end else begin
      abs_ext = e;
    end
  endfunction

  // Disabled slots enter the pipeline as zero.
  always_comb begin
    if (tu_enable) begin
      gated_s = tu;
    end else begin
      gated_s = '0;
    end
  end

  assign abs_i_s = abs_ext(gated_s[DATA_WIDTH-1:HW]);
  assign abs_q_s = abs_ext(gated_s[HW-1:0]);

  // Abs stage followed by ITER vectoring micro-rotations driving y toward zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= ITER; k++) begin
        x_r[k] <= '0;
        y_r[k] <= '0;
      end
    end else begin
      x_r[0] <= abs_i_s;
      y_r[0] <= abs_q_s;
      for (int k = 0; k < ITER; k++) begin
        if (!y_r[k][H]) begin
          x_r[k+1] <= x_r[k] + (y_r[k] >>> k);
          y_r[k+1] <= y_r[k] - (x_r[k] >>> k);
        end else begin
          x_r[k+1] <= x_r[k] - (y_r[k] >>> k);
          y_r[k+1] <= y_r[k] + (x_r[k] >>> k);
        end
      end
    end
  end

  // x stays non-negative through vectoring, so the gain multiply is unsigned.
  assign prod_s  = {15'b0, x_r[ITER][H-1:0]} * {{H{1'b0}}, GAIN_K};
  assign round_s = {1'b0, xg_r} + RND;
  assign r_s     = round_s >> S;
  assign sat_s   = (r_s > MAG_MAX);
  assign unused_s = ^{prod_s[14:0], x_r[ITER][H], y_r[ITER]};

  // Gain compensation and rounded, clipped quantization; invalid slots read zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      xg_r  <= '0;
      mag_r <= '0;
    end else begin
      xg_r <= prod_s[H+14:15];
      if (!vld_r[LAT-2]) begin
        mag_r <= '0;
      end else if (sat_s) begin
        mag_r <= '1;
      end else begin
        mag_r <= r_s[ADDR_WIDTH-1:0];
      end
    end
  end

  // Sample and valid delay line, LAT deep, aligned with mag.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= '0;
      for (int i = 0; i < LAT; i++) begin
        data_r[i] <= '0;
      end
    end else begin
      vld_r     <= {vld_r[LAT-2:0], tu_enable};
      data_r[0] <= gated_s;
      for (int i = 1; i < LAT; i++) begin
        data_r[i] <= data_r[i-1];
      end
    end
  end

`ifdef DPD_MAG_SAT_CNT_EN
  logic [15:0] sat_cnt_r;

  // Saturating count of valid outputs whose magnitude had to be clipped; clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt_r <= 16'd0;
    end else if (sat_clr) begin
      sat_cnt_r <= 16'd0;
    end else if (vld_r[LAT-2] && sat_s && (sat_cnt_r != 16'hFFFF)) begin
      sat_cnt_r <= sat_cnt_r + 16'd1;
    end else begin
      sat_cnt_r <= sat_cnt_r;
    end
  end

  assign sat_cnt = sat_cnt_r;
`endif

  assign tu_out        = data_r[LAT-1];
  assign tu_out_enable = vld_r[LAT-1];
  assign mag           = mag_r;

endmodule

// File: tb/tb_dpd_mag_cordic.sv
// Self-checking bench for dpd_mag_cordic: vector table plus scoreboard keyed on due cycle.
// Expected magnitudes come from constants or a real-valued sqrt model with 1 LSB tolerance.
module tb_dpd_mag_cordic;
  localparam int LAT = 15;

  logic        clk;
  logic        rst;
  logic        tu_enable;
  logic [31:0] tu;
  logic [31:0] tu_out;
  logic        tu_out_enable;
  logic [9:0]  mag;
`ifdef DPD_MAG_SAT_CNT_EN
  logic        sat_clr;
  logic [15:0] sat_cnt;
`endif

  dpd_mag_cordic dut (
    .clk           (clk),
    .rst           (rst),
    .tu_enable     (tu_enable),
    .tu            (tu),
`ifdef DPD_MAG_SAT_CNT_EN
    .sat_clr       (sat_clr),
    .sat_cnt       (sat_cnt),
`endif
    .tu_out        (tu_out),
    .tu_out_enable (tu_out_enable),
    .mag           (mag)
  );

  typedef struct {
    int          due;
    logic        en;
    logic [31:0] tu;
    int          mag;
    int          tol;
  } rec_t;

  typedef struct {
    logic [31:0] tu;
    int          mag;
    int          tol;
  } vec_t;

  rec_t sb_q[$];
  vec_t vecs [10];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   n_sent   = 0;
  int   n_seen   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp, input int tol);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
    end
  endtask

  function automatic logic [31:0] iq(input int i, input int q);
    logic [15:0] a;
    logic [15:0] b;
    a = i[15:0];
    b = q[15:0];
    return {a, b};
  endfunction

  function automatic int model_mag(input logic [31:0] s);
    real ri;
    real rq;
    int  r;
    ri = real'(int'($signed(s[31:16])));
    rq = real'(int'($signed(s[15:0])));
    r  = $rtoi($sqrt(ri * ri + rq * rq) / 32.0 + 0.5);
    if (r > 1023) r = 1023;
    return r;
  endfunction

  // Compare every output cycle that has a scoreboard entry due.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      rec_t r;
      r = sb_q.pop_front();
      if (r.due < cyc) begin
        check("sb_late", cyc, r.due, 0);
      end else begin
        check("tu_out_enable", tu_out_enable, r.en, 0);
        check("tu_out", tu_out, r.tu, 0);
        check("mag", mag, r.mag, r.tol);
        if (tu_out_enable) n_seen++;
      end
    end
  end

  task automatic drive(input logic [31:0] s, input logic en, input int m, input int tol);
    rec_t r;
    tu        = s;
    tu_enable = en;
    r.due = cyc + LAT;
    r.en  = en;
    r.tu  = en ? s : 32'd0;
    r.mag = en ? m : 0;
    r.tol = en ? tol : 0;
    sb_q.push_back(r);
    if (en) n_sent++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(32'd0, 1'b0, 0, 0);
  endtask

  // Flush in-flight expectations and expect all-zero outputs until new samples emerge.
  task automatic do_reset(input int n);
    rst       = 1'b1;
    tu_enable = 1'b0;
    tu        = 32'd0;
    foreach (sb_q[i]) if (sb_q[i].en) n_sent--;
    sb_q.delete();
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      rec_t r;
      r.due = cyc + i;
      r.en  = 1'b0;
      r.tu  = 32'd0;
      r.mag = 0;
      r.tol = 0;
      sb_q.push_back(r);
    end
  endtask

  initial begin
    logic [31:0] s;
    logic        en;

    vecs[0] = '{iq(16384, 0),       512,  1};
    vecs[1] = '{iq(-20000, -20000), 884,  1};
    vecs[2] = '{iq(-32768, -32768), 1023, 0};
    vecs[3] = '{iq(0, 0),           0,    0};
    vecs[4] = '{iq(3000, 4000),     156,  1};
    vecs[5] = '{iq(0, -16384),      512,  1};
    vecs[6] = '{iq(-32768, 0),      1023, 1};
    vecs[7] = '{iq(32767, 32767),   1023, 0};
    vecs[8] = '{iq(-1, 1),          0,    1};
    vecs[9] = '{iq(100, -2000),     63,   1};

    rst       = 1'b1;
    tu_enable = 1'b0;
    tu        = 32'd0;
`ifdef DPD_MAG_SAT_CNT_EN
    sat_clr   = 1'b0;
`endif
    do_reset(3);

    // Isolated vectors: each valid output must be a single-cycle pulse at LAT.
    for (int v = 0; v < 10; v++) begin
      drive(vecs[v].tu, 1'b1, vecs[v].mag, vecs[v].tol);
      idle(2);
    end
    idle(LAT);

    // Ramp with alternating enable.
    for (int i = 0; i < 20; i++) begin
      s  = iq(i * 1500 - 14000, -i * 700);
      en = (i % 2 == 0);
      drive(s, en, model_mag(s), 1);
    end
    idle(LAT);

    // Random sweep, mostly back-to-back valid.
    for (int i = 0; i < 10000; i++) begin
      s  = $urandom;
      en = ($urandom_range(0, 9) != 0);
      drive(s, en, model_mag(s), 1);
    end

    // Reset with eight valid samples in flight, then a fresh sample.
    for (int i = 0; i < 8; i++) begin
      s = iq(4000 + i * 1000, -3000 - i * 500);
      drive(s, 1'b1, model_mag(s), 1);
    end
    do_reset(1);
    drive(iq(6400, 4800), 1'b1, 250, 1);
    idle(LAT + 2);

`ifdef DPD_MAG_SAT_CNT_EN
    do_reset(1);
    check("sat_cnt_reset", sat_cnt, 0, 0);
    drive(iq(-32768, -32768), 1'b1, 1023, 0);
    idle(LAT - 1);
    check("sat_cnt_inc", sat_cnt, 1, 0);
    drive(iq(-32768, -32768), 1'b1, 1023, 0);
    idle(LAT - 2);
    sat_clr = 1'b1;
    idle(1);
    sat_clr = 1'b0;
    check("sat_cnt_clr_prio", sat_cnt, 0, 0);
    idle(LAT + 2);
`endif

    idle(LAT + 2);
    check("valid_count", n_seen, n_sent, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
